// File: rtl/mem_pkg.sv
// Shared types and constants for the byte-addressed memory interface and its RAM.
// The optional misalignment trap in memory_interface is enabled with MISALIGN_TRAP_EN.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_XFER = 2'd2,
    ST_DONE = 2'd3
  } mem_state_e;

  localparam logic [1:0] DT_BYTE = 2'b00;
  localparam logic [1:0] DT_HALF = 2'b01;
  localparam logic [1:0] DT_WORD = 2'b10;

  localparam int WAIT_CYCLES_DEFAULT = 2;

  // Lane 3 is the lowest address (most significant byte of the 32-bit bus).
  function automatic logic [3:0] lane_mask(input logic [1:0] dt);
    case (dt)
      DT_BYTE: lane_mask = 4'b1000;
      DT_HALF: lane_mask = 4'b1100;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] dt, input logic [1:0] lsb);
    case (dt)
      DT_BYTE: misaligned = 1'b0;
      DT_HALF: misaligned = lsb[0];
      default: misaligned = (lsb != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/ram_bytes.sv
// Byte-wide RAM, 2^ADDR_W deep: synchronous write through four lane enables and
// combinational read of four consecutive bytes starting at addr (wrapping).
module ram_bytes #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] lane_addr [4];

  // Lane i sits at addr+i and carries bus bits [31-8i -: 8] (big-endian).
  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign lane_addr[i]          = addr + ADDR_W'(i);
    assign rdata[31-8*i -: 8]    = mem[lane_addr[i]];
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[3-i]) mem[lane_addr[i]] <= wdata[8*(3-i) +: 8];
    end
  end

endmodule

// File: rtl/memory_interface.sv
// Four-phase MFA/MOC memory interface with programmable wait states over ram_bytes.
// Define MISALIGN_TRAP_EN to trap misaligned accesses on MERR instead of forcing alignment.
module memory_interface
  import mem_pkg::*;
#(
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEFAULT,
  parameter int ADDR_W      = 8
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              MFA,
  input  logic              RW,
  input  logic [1:0]        DT,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [31:0]       DATA_IN,
  output logic [31:0]       DATA_OUT,
  output logic              MOC,
`ifdef MISALIGN_TRAP_EN
  output logic              MERR,
`endif
  output mem_state_e        fsm_state
);

  // Handshake: MFA rises and is held until MOC is seen; MOC stays high until the
  // edge that samples MFA low, after which IDLE may sample a new MFA.

  mem_state_e        state;
  mem_state_e        next_state;
  logic [3:0]        cnt;
  logic              rw_q;
  logic [1:0]        dt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       din_q;
  logic [31:0]       dout_q;
  logic [ADDR_W-1:0] eff_addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic [31:0]       rd_ext;
  logic [3:0]        ram_we;
  logic              trap;
`ifdef MISALIGN_TRAP_EN
  logic              merr_q;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (MFA) next_state = (WAIT_CYCLES == 0) ? ST_XFER : ST_WAIT;
      ST_WAIT: if (cnt <= 4'd1) next_state = ST_XFER;
      ST_XFER: next_state = ST_DONE;
      ST_DONE: if (!MFA) next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    MOC       = (state == ST_DONE);
    DATA_OUT  = dout_q;
    fsm_state = state;
`ifdef MISALIGN_TRAP_EN
    MERR      = merr_q;
`endif
  end

  // Lane steering and alignment are decoded from the latched request only, so
  // input changes after the sampling edge cannot disturb the access.
  always_comb begin
    eff_addr = addr_q;
`ifdef MISALIGN_TRAP_EN
    trap = misaligned(dt_q, addr_q[1:0]);
`else
    trap = 1'b0;
    if (dt_q == DT_HALF)  eff_addr[0]   = 1'b0;
    else if (dt_q[1])     eff_addr[1:0] = 2'b00;
`endif
    case (dt_q)
      DT_BYTE: begin
        wdata  = {din_q[7:0], 24'h0};
        rd_ext = {24'h0, rdata[31:24]};
      end
      DT_HALF: begin
        wdata  = {din_q[15:0], 16'h0};
        rd_ext = {16'h0, rdata[31:16]};
      end
      default: begin
        wdata  = din_q;
        rd_ext = rdata;
      end
    endcase
    ram_we = (state == ST_XFER && !rw_q && !trap) ? lane_mask(dt_q) : 4'b0000;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt    <= 4'd0;
      rw_q   <= 1'b0;
      dt_q   <= 2'b00;
      addr_q <= '0;
      din_q  <= 32'h0;
      dout_q <= 32'h0;
`ifdef MISALIGN_TRAP_EN
      merr_q <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (MFA) begin
            rw_q   <= RW;
            dt_q   <= DT;
            addr_q <= ADDR;
            din_q  <= DATA_IN;
            cnt    <= 4'(WAIT_CYCLES);
          end
        end
        ST_WAIT: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
        end
        ST_XFER: begin
          if (rw_q && !trap) dout_q <= rd_ext;
`ifdef MISALIGN_TRAP_EN
          if (trap) merr_q <= 1'b1;
`endif
        end
        ST_DONE: begin
`ifdef MISALIGN_TRAP_EN
          if (!MFA) merr_q <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

  ram_bytes #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (CLK),
    .we    (ram_we),
    .addr  (eff_addr),
    .wdata (wdata),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_memory_interface.sv
// Self-checking bench for memory_interface: byte-array reference model, per-cycle
// compare process, directed literal checks and randomized accesses.
module tb_memory_interface;
  import mem_pkg::*;

  localparam int W_MAIN = 2;
  localparam int PERIOD = 10;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #(PERIOD/2) CLK = ~CLK;

  logic        MFA = 1'b0, RW = 1'b0;
  logic [1:0]  DT = 2'b00;
  logic [7:0]  ADDR = 8'h00;
  logic [31:0] DATA_IN = 32'h0;
  logic [31:0] DATA_OUT;
  logic        MOC;
  logic        MERR;
  mem_state_e  fsm_state;

  logic        mfa0 = 1'b0, rw0 = 1'b0;
  logic [1:0]  dt0 = 2'b00;
  logic [7:0]  addr0 = 8'h00;
  logic [31:0] din0 = 32'h0;
  logic [31:0] dout0;
  logic        moc0;
  logic        merr0;
  mem_state_e  st0;

  memory_interface #(.WAIT_CYCLES(W_MAIN), .ADDR_W(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .MFA(MFA), .RW(RW), .DT(DT), .ADDR(ADDR),
    .DATA_IN(DATA_IN), .DATA_OUT(DATA_OUT), .MOC(MOC),
`ifdef MISALIGN_TRAP_EN
    .MERR(MERR),
`endif
    .fsm_state(fsm_state)
  );

  memory_interface #(.WAIT_CYCLES(0), .ADDR_W(8)) dut0 (
    .CLK(CLK), .RST_N(RST_N), .MFA(mfa0), .RW(rw0), .DT(dt0), .ADDR(addr0),
    .DATA_IN(din0), .DATA_OUT(dout0), .MOC(moc0),
`ifdef MISALIGN_TRAP_EN
    .MERR(merr0),
`endif
    .fsm_state(st0)
  );

`ifndef MISALIGN_TRAP_EN
  assign MERR  = 1'b0;
  assign merr0 = 1'b0;
`endif

  // ---------------- scoreboard / model ----------------
  int tests = 0;
  int fails = 0;
  logic [7:0]  mem_model [256];
  logic [31:0] exp_dout = 32'h0;
  logic        exp_moc  = 1'b0;
  logic        exp_merr = 1'b0;
  time         e0_t = 0, rise_t = 0, fall_t = 0;
  logic        moc_prev = 1'b0;
  logic        merr_at_rise = 1'b0;
  int          last_width = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_addr(input logic [7:0] a, input logic [1:0] dt);
`ifdef MISALIGN_TRAP_EN
    return a;
`else
    if (dt == DT_HALF) return {a[7:1], 1'b0};
    if (dt[1])         return {a[7:2], 2'b00};
    return a;
`endif
  endfunction

  function automatic int nbytes(input logic [1:0] dt);
    return (dt == DT_BYTE) ? 1 : (dt == DT_HALF) ? 2 : 4;
  endfunction

  task automatic model_apply(input logic rw, input logic [1:0] dt, input logic [7:0] a,
                             input logic [31:0] din);
    logic [7:0]  base;
    logic [7:0]  ai;
    logic [31:0] v;
    int          n;
    base = model_addr(a, dt);
    n    = nbytes(dt);
`ifdef MISALIGN_TRAP_EN
    if ((dt == DT_HALF && a[0]) || (dt[1] && a[1:0] != 2'b00)) begin
      exp_merr = 1'b1;
      return;
    end
`endif
    if (rw) begin
      v = 32'h0;
      for (int i = 0; i < n; i++) begin
        ai = base + 8'(i);
        v  = {v[23:0], mem_model[ai]};
      end
      exp_dout = v;
    end else begin
      for (int i = 0; i < n; i++) begin
        ai = base + 8'(i);
        mem_model[ai] = din[8*(n-1-i) +: 8];
      end
    end
  endtask

  // ---------------- compare process ----------------
  always begin
    @(posedge CLK);
    #1;
    check("moc", {31'h0, MOC}, {31'h0, exp_moc});
    check("data_out", DATA_OUT, exp_dout);
`ifdef MISALIGN_TRAP_EN
    check("merr", {31'h0, MERR}, {31'h0, exp_merr});
`endif
    if (MOC && !moc_prev) begin
      rise_t = $time;
      merr_at_rise = MERR;
    end
    if (!MOC && moc_prev) begin
      fall_t = $time;
      last_width = 32'((fall_t - rise_t) / PERIOD);
    end
    moc_prev = MOC;
  end

  // ---------------- driver ----------------
  task automatic access(input logic rw, input logic [1:0] dt, input logic [7:0] a,
                        input logic [31:0] din, input int hold, input bit drop_early);
    @(negedge CLK);
    MFA = 1'b1; RW = rw; DT = dt; ADDR = a; DATA_IN = din;
    @(posedge CLK);
    e0_t = $time;
    @(negedge CLK);
    RW = 1'($urandom); DT = 2'($urandom); ADDR = 8'($urandom); DATA_IN = $urandom;
    if (drop_early) MFA = 1'b0;
    repeat (W_MAIN) @(posedge CLK);
    @(posedge CLK);
    model_apply(rw, dt, a, din);
    exp_moc = 1'b1;
    if (!drop_early) begin
      repeat (hold) @(posedge CLK);
      @(negedge CLK);
      MFA = 1'b0;
    end
    @(posedge CLK);
    exp_moc  = 1'b0;
    exp_merr = 1'b0;
  endtask

  task automatic zero_wait_test();
    @(negedge CLK);
    mfa0 = 1'b1; rw0 = 1'b0; dt0 = DT_WORD; addr0 = 8'h04; din0 = 32'hCAFEF00D;
    @(posedge CLK); #1 check("w0_wr_e0_moc", {31'h0, moc0}, 32'h0);
    @(posedge CLK); #1 check("w0_wr_e1_moc", {31'h0, moc0}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1 check("w0_hold_moc", {31'h0, moc0}, 32'h1);
    end
    @(negedge CLK); mfa0 = 1'b0;
    @(posedge CLK); #1 check("w0_release_moc", {31'h0, moc0}, 32'h0);
    @(negedge CLK);
    mfa0 = 1'b1; rw0 = 1'b1; din0 = 32'h0;
    @(posedge CLK); #1 check("w0_rd_e0_moc", {31'h0, moc0}, 32'h0);
    @(posedge CLK); #1;
    check("w0_rd_e1_moc", {31'h0, moc0}, 32'h1);
    check("w0_rd_data", dout0, 32'hCAFEF00D);
    @(negedge CLK); mfa0 = 1'b0;
    @(posedge CLK); #1;
    check("w0_rd_release_moc", {31'h0, moc0}, 32'h0);
    check("w0_rd_data_hold", dout0, 32'hCAFEF00D);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(posedge CLK);
    #2;
    check("rst_moc", {31'h0, MOC}, 32'h0);
    check("rst_data_out", DATA_OUT, 32'h0);
    check("rst_state", 32'(fsm_state), 32'(ST_IDLE));
    check("rst_merr", {31'h0, MERR}, 32'h0);
    check("rst_moc0", {31'h0, moc0}, 32'h0);
    @(negedge CLK);
    RST_N = 1'b1;

    for (int i = 0; i < 64; i++) access(1'b0, DT_WORD, 8'(i*4), $urandom, 0, 1'b0);

    access(1'b0, DT_WORD, 8'h10, 32'hDEADBEEF, 2, 1'b0);
    #2 check("latency_w2", 32'((rise_t - e0_t) / PERIOD), 32'd3);
    check("held_width", 32'(last_width), 32'd3);
    access(1'b1, DT_BYTE, 8'h10, 32'h0, 0, 1'b0);
    #2 check("byte_read_10", DATA_OUT, 32'h000000DE);
    access(1'b0, DT_BYTE, 8'h13, 32'h0000005A, 0, 1'b0);
    access(1'b1, DT_HALF, 8'h12, 32'h0, 0, 1'b0);
    #2 check("half_read_12", DATA_OUT, 32'h0000BE5A);
    access(1'b1, DT_WORD, 8'h10, 32'h0, 0, 1'b1);
    #2 check("drop_early_width", 32'(last_width), 32'd1);
    check("drop_early_data", DATA_OUT, 32'hDEADBE5A);

    access(1'b0, DT_WORD, 8'h20, 32'hA1B2C3D4, 1, 1'b0);
    @(negedge CLK);
    MFA = 1'b1; RW = 1'b0; DT = DT_WORD; ADDR = 8'h20; DATA_IN = 32'h11223344;
    @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b0; MFA = 1'b0;
    exp_moc = 1'b0; exp_dout = 32'h0; exp_merr = 1'b0;
    #1;
    check("abort_moc", {31'h0, MOC}, 32'h0);
    check("abort_state", 32'(fsm_state), 32'(ST_IDLE));
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    access(1'b1, DT_WORD, 8'h20, 32'h0, 0, 1'b0);
    #2 check("abort_ram_unchanged", DATA_OUT, 32'hA1B2C3D4);

    access(1'b0, DT_WORD, 8'h21, 32'h01020304, 0, 1'b0);
`ifdef MISALIGN_TRAP_EN
    #2 check("misalign_merr", {31'h0, merr_at_rise}, 32'h1);
`endif
    access(1'b1, DT_WORD, 8'h20, 32'h0, 0, 1'b0);
`ifdef MISALIGN_TRAP_EN
    #2 check("misalign_ram", DATA_OUT, 32'hA1B2C3D4);
`else
    #2 check("misalign_forced", DATA_OUT, 32'h01020304);
`endif

    for (int i = 0; i < 150; i++) begin
      access(1'($urandom), 2'($urandom), 8'($urandom), $urandom,
             int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
    end

    zero_wait_test();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #(PERIOD * 20000);
    fails++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
